div_issue_ctrl: RTL and testbench
=================================

// Module: div_issue_ctrl
// PURPOSE
//  EX-stage requester for the multi-cycle divider. Launches DIV/DIVU, holds the divider
//  start/cancel handshake and stalls the pipeline until the result returns. Captures
//  {HI,LO} and presents it to the EX->MEM HI/LO write path. Aborts on pipeline flush.
// PARAMETERS
//  DATA_WIDTH   32  operand width; result bus is 2*DATA_WIDTH
//  TIMEOUT      48  max cycles in BUSY before the watchdog aborts (must be > 36)
//  DRAIN_CYCLES 2   start-low cycles forced after a cancel before the next issue
// PORTS
//  clk             in   1     clock
//  rst_n           in   1     synchronous, active-low reset
//  ex_div_valid_in in   1     EX holds a DIV/DIVU instruction
//  ex_signed_in    in   1     1 = DIV (signed), 0 = DIVU
//  ex_rs_in        in   32    dividend (rs)
//  ex_rt_in        in   32    divisor (rt)
//  flush_in        in   1     exception/flush; kills the EX instruction
//  stall_hold_in   in   1     downstream stall; EX instruction does not advance
//  div_res_in      in   64    divider result {remainder[63:32], quotient[31:0]}
//  div_ready_in    in   1     divider result valid
//  div_start_out   out  1     divider start; held high for the whole transaction
//  div_cancel_out  out  1     divider cancel pulse
//  div_signed_out  out  1     registered copy of ex_signed_in at issue
//  div_dived_out   out  32    registered dividend
//  div_div_out     out  32    registered divisor
//  stall_req_out   out  1     pipeline stall request (combinational)
//  hilo_valid_out  out  1     hi_out/lo_out valid for the EX instruction
//  hi_out          out  32    remainder
//  lo_out          out  32    quotient
//  timeout_err_out out  1     one-cycle pulse on watchdog abort
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; counters 0. Reset mid-transaction: start drops the
//   next cycle; the divider returns to free by its own start-low rule.
//  States: IDLE, BUSY, DONE, DRAIN.
//  IDLE: if ex_div_valid_in & !flush_in & drain_cnt==0 -> latch signed/rs/rt, start<=1,
//   go to BUSY. stall_req_out = ex_div_valid_in & !flush_in (combinational, issue cycle).
//  BUSY: start held 1; operand outputs stable; stall_req_out=1; cycle counter increments.
//   - flush_in: start<=0, cancel<=1 for one cycle, drain_cnt<=DRAIN_CYCLES, go DRAIN.
//   - div_ready_in (first cycle of BUSY not excluded): hi<=res[63:32], lo<=res[31:0],
//     hilo_valid<=1, start<=0, go DONE. flush_in wins over ready in the same cycle.
//   - counter==TIMEOUT-1 without ready: same as flush path + timeout_err_out pulse;
//     hilo_valid stays 0. EX instruction then advances with no HI/LO write.
//  DONE: start=0, stall_req_out=0; hilo_valid_out=1; div_ready_in ignored (stale for 1
//   cycle while the divider sees start low). Exit to IDLE when !stall_hold_in | flush_in
//   (instruction advanced or killed); hilo_valid<=0 on exit. Minimum 1 cycle in DONE,
//   so start is low >=1 cycle between back-to-back divides.
//  DRAIN: start=0, cancel=0; drain_cnt decrements; IDLE when 0. Covers a divider that
//   ignores cancel in its divide-by-zero path and must see start low to return free.
//   stall_req_out = ex_div_valid_in & !flush_in (a new divide waits).
//  Divider contract: nonzero divisor ~36 cycles start->ready, zero divisor ~3 cycles with
//   result 0; controller is latency-agnostic up to TIMEOUT.
//  Cancel is only asserted from BUSY; never together with start=1.
// TESTING
//  DIVU 100/7, stub ready after 36 cyc -> start held 36 cyc, stall 37 cyc, lo=14, hi=2.
//  DIV -7/2 -> div_signed_out=1, lo=0xFFFFFFFD, hi=0xFFFFFFFF; hilo_valid 1 cycle.
//  DIVU x/0, stub ready after 3 cyc -> hi=lo=0, stall released cycle after ready.
//  flush_in at BUSY cycle 10 -> cancel 1 cyc, start 0, 2 DRAIN cyc, no hilo_valid.
//  stall_hold_in=1 for 5 cyc after ready -> DONE held 5 cyc, no re-issue, then IDLE.
//  stub never readies -> cancel + timeout_err_out at BUSY cycle 48, then DRAIN.

Source files
------------

// File: rtl/div_issue_ctrl_if.sv
// Handshake bundle between the EX stage, the divider issue controller and the divider.
// The controller takes the slave view; the surrounding pipeline/divider take the master view.
interface div_issue_ctrl_if #(
    parameter int DATA_WIDTH = 32
);
    logic                    ex_div_valid_in;
    logic                    ex_signed_in;
    logic [DATA_WIDTH-1:0]   ex_rs_in;
    logic [DATA_WIDTH-1:0]   ex_rt_in;
    logic                    flush_in;
    logic                    stall_hold_in;
    logic [2*DATA_WIDTH-1:0] div_res_in;
    logic                    div_ready_in;
    logic                    div_start_out;
    logic                    div_cancel_out;
    logic                    div_signed_out;
    logic [DATA_WIDTH-1:0]   div_dived_out;
    logic [DATA_WIDTH-1:0]   div_div_out;
    logic                    stall_req_out;
    logic                    hilo_valid_out;
    logic [DATA_WIDTH-1:0]   hi_out;
    logic [DATA_WIDTH-1:0]   lo_out;
    logic                    timeout_err_out;

    modport slave (
        input  ex_div_valid_in, ex_signed_in, ex_rs_in, ex_rt_in, flush_in, stall_hold_in,
               div_res_in, div_ready_in,
        output div_start_out, div_cancel_out, div_signed_out, div_dived_out, div_div_out,
               stall_req_out, hilo_valid_out, hi_out, lo_out, timeout_err_out
    );

    modport master (
        output ex_div_valid_in, ex_signed_in, ex_rs_in, ex_rt_in, flush_in, stall_hold_in,
               div_res_in, div_ready_in,
        input  div_start_out, div_cancel_out, div_signed_out, div_dived_out, div_div_out,
               stall_req_out, hilo_valid_out, hi_out, lo_out, timeout_err_out
    );
endinterface

// File: rtl/div_issue_ctrl.sv
// EX-stage requester for the multi-cycle divider: issues DIV/DIVU, stalls until the
// result returns, presents {HI,LO}, and aborts on flush or watchdog expiry.
module div_issue_ctrl #(
    parameter int DATA_WIDTH   = 32,
    parameter int TIMEOUT      = 48,
    parameter int DRAIN_CYCLES = 2
) (
    input logic             clk,
    input logic             rst_n,
    div_issue_ctrl_if.slave bus
);
    localparam int CNT_W   = $clog2(TIMEOUT);
    localparam int DRAIN_W = (DRAIN_CYCLES > 0) ? $clog2(DRAIN_CYCLES + 1) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE, DRAIN} state_t;

    state_t                state, state_nxt;
    logic [CNT_W-1:0]      busy_cnt;
    logic [DRAIN_W-1:0]    drain_cnt;
    logic                  start, cancel, signed_q, hilo_valid, timeout_err;
    logic [DATA_WIDTH-1:0] dived, divisor, hi, lo;
    logic                  issue, capture, abort, timeout_hit, stall_req;

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt   = state;
        issue       = 1'b0;
        capture     = 1'b0;
        abort       = 1'b0;
        timeout_hit = 1'b0;
        stall_req   = 1'b0;
        case (state)
            IDLE: begin
                stall_req = bus.ex_div_valid_in && !bus.flush_in;
                if (stall_req && drain_cnt == '0) begin
                    issue     = 1'b1;
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                stall_req = 1'b1;
                // Flush beats a same-cycle ready; the watchdog only fires without ready.
                if (bus.flush_in) begin
                    abort     = 1'b1;
                    state_nxt = DRAIN;
                end else if (bus.div_ready_in) begin
                    capture   = 1'b1;
                    state_nxt = DONE;
                end else if (busy_cnt == CNT_W'(TIMEOUT - 1)) begin
                    abort       = 1'b1;
                    timeout_hit = 1'b1;
                    state_nxt   = DRAIN;
                end
            end
            DONE: begin
                if (!bus.stall_hold_in || bus.flush_in) state_nxt = IDLE;
            end
            DRAIN: begin
                stall_req = bus.ex_div_valid_in && !bus.flush_in;
                if (drain_cnt <= DRAIN_W'(1)) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            start       <= 1'b0;
            cancel      <= 1'b0;
            signed_q    <= 1'b0;
            dived       <= '0;
            divisor     <= '0;
            hi          <= '0;
            lo          <= '0;
            hilo_valid  <= 1'b0;
            timeout_err <= 1'b0;
            busy_cnt    <= '0;
            drain_cnt   <= '0;
        end else begin
            cancel      <= abort;
            timeout_err <= timeout_hit;

            if (issue) begin
                start    <= 1'b1;
                signed_q <= bus.ex_signed_in;
                dived    <= bus.ex_rs_in;
                divisor  <= bus.ex_rt_in;
                busy_cnt <= '0;
            end else if (state == BUSY) begin
                busy_cnt <= busy_cnt + CNT_W'(1);
            end

            if (capture) begin
                hi         <= bus.div_res_in[2*DATA_WIDTH-1:DATA_WIDTH];
                lo         <= bus.div_res_in[DATA_WIDTH-1:0];
                hilo_valid <= 1'b1;
                start      <= 1'b0;
            end

            // The divider's divide-by-zero path ignores cancel and only frees on start low.
            if (abort) begin
                start     <= 1'b0;
                drain_cnt <= DRAIN_W'(DRAIN_CYCLES);
            end else if (state == DRAIN && drain_cnt != '0) begin
                drain_cnt <= drain_cnt - DRAIN_W'(1);
            end

            if (state == DONE && state_nxt == IDLE) hilo_valid <= 1'b0;
        end
    end

    assign bus.div_start_out   = start;
    assign bus.div_cancel_out  = cancel;
    assign bus.div_signed_out  = signed_q;
    assign bus.div_dived_out   = dived;
    assign bus.div_div_out     = divisor;
    assign bus.stall_req_out   = rst_n && stall_req;
    assign bus.hilo_valid_out  = hilo_valid;
    assign bus.hi_out          = hi;
    assign bus.lo_out          = lo;
    assign bus.timeout_err_out = timeout_err;
endmodule

// File: tb/tb_div_issue_ctrl.sv
// Bench for div_issue_ctrl: a divider stub with programmable latency plus a transaction-level
// timing/result model; directed scenarios followed by randomized back-to-back traffic.
module tb_div_issue_ctrl;
    localparam int DW      = 32;
    localparam int TIMEOUT = 48;
    localparam int DRAIN   = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    div_issue_ctrl_if #(.DATA_WIDTH(DW)) bus ();

    div_issue_ctrl #(
        .DATA_WIDTH  (DW),
        .TIMEOUT     (TIMEOUT),
        .DRAIN_CYCLES(DRAIN)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference divide: truncating quotient, remainder takes the dividend's sign; /0 gives 0.
    function automatic logic [2*DW-1:0] ref_div(input logic sgn, input logic [DW-1:0] a,
                                                input logic [DW-1:0] b);
        logic [DW-1:0] q;
        logic [DW-1:0] r;
        if (b == '0) return '0;
        if (sgn) begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
        end else begin
            q = a / b;
            r = a % b;
        end
        return {r, q};
    endfunction

    // Divider stub: ready on the stub_lat-th cycle of start high, and stays up one extra stale cycle.
    int   stub_lat   = 36;
    bit   stub_never = 1'b0;
    int   stub_cnt   = 0;
    logic stub_stale = 1'b0;
    logic ready_now;

    assign ready_now        = bus.div_start_out && !stub_never && (stub_cnt == stub_lat - 1);
    assign bus.div_ready_in = ready_now || stub_stale;
    assign bus.div_res_in   = ref_div(bus.div_signed_out, bus.div_dived_out, bus.div_div_out);

    always @(posedge clk) begin
        stub_cnt   <= bus.div_start_out ? stub_cnt + 1 : 0;
        stub_stale <= ready_now;
    end

    // One instruction. Cycle 0 presents it; 'pre' cycles are expected to pass before issue.
    // lat<0 = divider never readies; flush_at>0 = flush on that BUSY cycle; hold = DONE cycles.
    task automatic run_div(input string name, input logic sgn, input logic [DW-1:0] rs,
                           input logic [DW-1:0] rt, input int lat, input int hold,
                           input int flush_at, input int pre, input int tail,
                           output logic [DW-1:0] hi_o, output logic [DW-1:0] lo_o);
        int end_c, exp_start, n_start, first_start, n_stall, n_cancel, cancel_c;
        int n_terr, terr_c, n_valid, first_valid, op_bad;
        bit timed_out, aborted;
        logic [2*DW-1:0] exp;
        timed_out  = (lat < 0);
        aborted    = timed_out || (flush_at > 0);
        stub_lat   = lat;
        stub_never = timed_out;
        if (flush_at > 0)   exp_start = flush_at;
        else if (timed_out) exp_start = TIMEOUT;
        else                exp_start = lat;
        end_c = aborted ? pre + exp_start : pre + lat + hold;
        n_start = 0; first_start = -1; n_stall = 0; n_cancel = 0; cancel_c = -1;
        n_terr = 0; terr_c = -1; n_valid = 0; first_valid = -1; op_bad = 0;
        hi_o = 'x; lo_o = 'x;

        for (int c = 0; c <= end_c + tail; c++) begin
            bus.ex_div_valid_in = (c <= end_c);
            bus.ex_signed_in    = sgn;
            bus.ex_rs_in        = rs;
            bus.ex_rt_in        = rt;
            bus.flush_in        = (flush_at > 0) && (c == pre + flush_at);
            bus.stall_hold_in   = !aborted && (c < pre + lat + hold);
            @(negedge clk);
            if (bus.div_start_out) begin
                n_start++;
                if (first_start < 0) first_start = c;
                if ({bus.div_signed_out, bus.div_dived_out, bus.div_div_out} !== {sgn, rs, rt})
                    op_bad++;
            end
            if (bus.stall_req_out) n_stall++;
            if (bus.div_cancel_out) begin
                n_cancel++;
                if (cancel_c < 0) cancel_c = c;
            end
            if (bus.timeout_err_out) begin
                n_terr++;
                if (terr_c < 0) terr_c = c;
            end
            if (bus.hilo_valid_out) begin
                n_valid++;
                if (first_valid < 0) begin
                    first_valid = c;
                    hi_o = bus.hi_out;
                    lo_o = bus.lo_out;
                end
            end
            @(posedge clk);
            #1;
        end

        checks++;
        if (n_start !== exp_start || first_start !== pre + 1) begin
            errors++;
            $display("FAIL %s start: %0d cycles from cycle %0d, required %0d cycles from cycle %0d",
                     name, n_start, first_start, exp_start, pre + 1);
        end
        checks++;
        if (n_stall !== pre + exp_start + 1) begin
            errors++;
            $display("FAIL %s stall_req: %0d cycles, required %0d", name, n_stall, pre + exp_start + 1);
        end
        checks++;
        if (n_cancel !== (aborted ? 1 : 0) || cancel_c !== (aborted ? pre + exp_start + 1 : -1)) begin
            errors++;
            $display("FAIL %s cancel: %0d pulses at cycle %0d, required %0d at cycle %0d", name,
                     n_cancel, cancel_c, aborted ? 1 : 0, aborted ? pre + exp_start + 1 : -1);
        end
        checks++;
        if (n_terr !== (timed_out ? 1 : 0) || terr_c !== (timed_out ? pre + exp_start + 1 : -1)) begin
            errors++;
            $display("FAIL %s timeout_err: %0d pulses at cycle %0d, required %0d at cycle %0d", name,
                     n_terr, terr_c, timed_out ? 1 : 0, timed_out ? pre + exp_start + 1 : -1);
        end
        checks++;
        if (op_bad !== 0) begin
            errors++;
            $display("FAIL %s operands: %0d cycles with wrong signed/dividend/divisor, required 0",
                     name, op_bad);
        end
        checks++;
        if (n_valid !== (aborted ? 0 : hold)) begin
            errors++;
            $display("FAIL %s hilo_valid: %0d cycles, required %0d", name, n_valid, aborted ? 0 : hold);
        end
        if (!aborted) begin
            exp = ref_div(sgn, rs, rt);
            checks++;
            if (first_valid !== pre + lat + 1 || {hi_o, lo_o} !== exp) begin
                errors++;
                $display("FAIL %s result: cycle %0d hi=%h lo=%h, required cycle %0d hi=%h lo=%h", name,
                         first_valid, hi_o, lo_o, pre + lat + 1, exp[2*DW-1:DW], exp[DW-1:0]);
            end
        end
    endtask

    task automatic drive_idle();
        bus.ex_div_valid_in = 1'b0;
        bus.ex_signed_in    = 1'b0;
        bus.ex_rs_in        = '0;
        bus.ex_rt_in        = '0;
        bus.flush_in        = 1'b0;
        bus.stall_hold_in   = 1'b0;
    endtask

    task automatic test_reset();
        drive_idle();
        bus.ex_div_valid_in = 1'b1;
        bus.ex_rt_in        = 32'd5;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({bus.div_start_out, bus.div_cancel_out, bus.div_signed_out, bus.div_dived_out,
             bus.div_div_out, bus.stall_req_out, bus.hilo_valid_out, bus.hi_out, bus.lo_out,
             bus.timeout_err_out} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: start=%b cancel=%b stall=%b hilo_valid=%b terr=%b, required all 0",
                     bus.div_start_out, bus.div_cancel_out, bus.stall_req_out, bus.hilo_valid_out,
                     bus.timeout_err_out);
        end
        @(posedge clk);
        #1;
        drive_idle();
        rst_n = 1'b1;
    endtask

    task automatic test_reset_mid();
        drive_idle();
        stub_lat = 36; stub_never = 1'b0;
        bus.ex_div_valid_in = 1'b1;
        bus.ex_rs_in        = 32'd77;
        bus.ex_rt_in        = 32'd3;
        bus.stall_hold_in   = 1'b1;
        repeat (6) begin
            @(posedge clk);
            #1;
        end
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        checks++;
        if ({bus.div_start_out, bus.stall_req_out, bus.hilo_valid_out, bus.div_dived_out,
             bus.div_cancel_out} !== '0) begin
            errors++;
            $display("FAIL reset_mid: start=%b stall=%b hilo_valid=%b dived=%h cancel=%b, required all 0",
                     bus.div_start_out, bus.stall_req_out, bus.hilo_valid_out, bus.div_dived_out,
                     bus.div_cancel_out);
        end
        @(posedge clk);
        #1;
        drive_idle();
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_divu_basic();
        logic [DW-1:0] hi, lo;
        run_div("divu_100_7", 1'b0, 32'd100, 32'd7, 36, 1, 0, 0, 2, hi, lo);
        checks++;
        if (hi !== 32'd2 || lo !== 32'd14) begin
            errors++;
            $display("FAIL divu_100_7_const: hi=%0d lo=%0d, required hi=2 lo=14", hi, lo);
        end
    endtask

    task automatic test_div_signed();
        logic [DW-1:0] hi, lo;
        run_div("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 36, 1, 0, 0, 2, hi, lo);
        checks++;
        if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFD) begin
            errors++;
            $display("FAIL div_m7_2_const: hi=%h lo=%h, required hi=ffffffff lo=fffffffd", hi, lo);
        end
    endtask

    task automatic test_div_zero();
        logic [DW-1:0] hi, lo;
        run_div("divu_by_zero", 1'b0, 32'd12345, 32'd0, 3, 1, 0, 0, 2, hi, lo);
        checks++;
        if (hi !== '0 || lo !== '0) begin
            errors++;
            $display("FAIL divu_by_zero_const: hi=%h lo=%h, required 0 and 0", hi, lo);
        end
    endtask

    task automatic test_flush();
        logic [DW-1:0] hi, lo;
        run_div("flush_b10", 1'b0, 32'd1000, 32'd3, 36, 1, 10, 0, 1, hi, lo);
        run_div("after_flush", 1'b0, 32'd1000, 32'd3, 36, 1, 0, DRAIN - 1, 0, hi, lo);
        run_div("flush_vs_ready", 1'b0, 32'd50, 32'd5, 20, 1, 20, 0, 1, hi, lo);
        run_div("after_flush_ready", 1'b1, 32'hFFFF_FF00, 32'd16, 5, 1, 0, DRAIN - 1, 2, hi, lo);
    endtask

    task automatic test_hold();
        logic [DW-1:0] hi, lo;
        run_div("hold_5", 1'b0, 32'd999, 32'd10, 12, 5, 0, 0, 3, hi, lo);
    endtask

    task automatic test_ready_first();
        logic [DW-1:0] hi, lo;
        run_div("ready_first_busy", 1'b0, 32'd81, 32'd9, 1, 1, 0, 0, 0, hi, lo);
        run_div("back_after_first", 1'b1, 32'h8000_0001, 32'hFFFF_FFFD, 2, 2, 0, 0, 2, hi, lo);
    endtask

    task automatic test_timeout();
        logic [DW-1:0] hi, lo;
        run_div("timeout", 1'b0, 32'd9, 32'd4, -1, 1, 0, 0, 1, hi, lo);
        run_div("after_timeout", 1'b0, 32'd9, 32'd4, 7, 1, 0, DRAIN - 1, 2, hi, lo);
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] hi, lo, rs, rt;
        logic sgn;
        int lat, hold, flush_at, pre, tail, mode;
        pre = 0;
        for (int n = 0; n < 14; n++) begin
            sgn = 1'($urandom_range(0, 1));
            rs  = $urandom;
            case ($urandom_range(0, 3))
                0:       rt = $urandom;
                1:       rt = 32'($urandom_range(1, 15));
                2:       rt = '0;
                default: rt = ~32'($urandom_range(0, 8));
            endcase
            if (sgn && rs == 32'h8000_0000 && rt == '1) rt = 32'd3;
            lat      = (rt == '0) ? 3 : int'($urandom_range(1, 44));
            hold     = int'($urandom_range(1, 3));
            flush_at = 0;
            mode     = int'($urandom_range(0, 7));
            if (mode == 0)      lat = -1;
            else if (mode <= 2) flush_at = int'($urandom_range(1, lat));
            tail = (lat < 0 || flush_at > 0) ? 1 : 0;
            if (n == 13) tail = 3;
            run_div($sformatf("rand%0d", n), sgn, rs, rt, lat, hold, flush_at, pre, tail, hi, lo);
            pre = (lat < 0 || flush_at > 0) ? DRAIN - 1 : 0;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached before the summary");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_divu_basic();
        test_div_signed();
        test_div_zero();
        test_flush();
        test_hold();
        test_ready_first();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
